// File: rtl/mem_access_stage.sv
// MEM stage: drives a handshaked data-memory port, stalls the front of the pipe while an
// access is outstanding, aborts after TIMEOUT request cycles, and holds the MEM/WB register.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALU_result_i,
  input  logic [31:0] Write_Data_i,
  input  logic [4:0]  RD_addr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        bus_err_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ALU_result_o,
  output logic [31:0] Read_Data_o,
  output logic [4:0]  RD_addr_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ABORT} state_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd_addr;
  } memwb_t;

  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  memwb_t           wb_q;
  logic             op, complete, in_abort;

  assign op       = MemRead_i | MemWrite_i;
  assign in_abort = (state_q == S_ABORT);

  // Combinational request so a zero-wait memory can ack in the issuing cycle.
  assign mem_req_o   = op & ~rst_i & ~in_abort;
  assign mem_we_o    = MemWrite_i;
  assign mem_addr_o  = ALU_result_i;
  assign mem_wdata_o = Write_Data_i;
  assign stall_o     = mem_req_o & ~mem_ack_i;
  assign complete    = mem_req_o & mem_ack_i;

  // cnt_q counts request cycles already spent; abort once TIMEOUT of them saw no ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (op && !mem_ack_i) begin
          if (TO == ONE) begin
            state_d = S_ABORT;
            cnt_d   = '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = ONE;
          end
        end
      end
      S_WAIT: begin
        if (complete || !op) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q + ONE == TO) begin
          state_d = S_ABORT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_ABORT: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wb_q      <= '0;
      bus_err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (in_abort) bus_err_o <= 1'b1;
      // Bubble on stall/abort edges so WB never repeats or commits a faulted write.
      if (in_abort || stall_o) begin
        wb_q.reg_write  <= 1'b0;
        wb_q.mem_to_reg <= 1'b0;
      end else begin
        wb_q.reg_write  <= RegWrite_i;
        wb_q.mem_to_reg <= MemtoReg_i;
        wb_q.alu_result <= ALU_result_i;
        wb_q.rd_addr    <= RD_addr_i;
        if (complete && !MemWrite_i) wb_q.read_data <= mem_rdata_i;
      end
    end
  end

  assign RegWrite_o   = wb_q.reg_write;
  assign MemtoReg_o   = wb_q.mem_to_reg;
  assign ALU_result_o = wb_q.alu_result;
  assign Read_Data_o  = wb_q.read_data;
  assign RD_addr_o    = wb_q.rd_addr;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, reset-during-wait sequence,
// and randomized transactions checked against a transaction-level model.
module tb_mem_access_stage;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic [31:0] ALU_result_i, Write_Data_i;
  logic [4:0]  RD_addr_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o, bus_err_o;
  logic        RegWrite_o, MemtoReg_o;
  logic [31:0] ALU_result_o, Read_Data_o;
  logic [4:0]  RD_addr_o;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALU_result_i(ALU_result_i), .Write_Data_i(Write_Data_i),
    .RD_addr_i(RD_addr_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .bus_err_o(bus_err_o),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .ALU_result_o(ALU_result_o),
    .Read_Data_o(Read_Data_o), .RD_addr_o(RD_addr_o)
  );

  typedef struct {
    logic        rw, m2r, mr, mw;
    logic [31:0] alu, wdata;
    logic [4:0]  rd;
    int          delay;      // request cycles without ack before the ack cycle
    logic [31:0] rdata;
    logic        e_rw, e_m2r;
    logic [31:0] e_alu, e_rdata;
    logic [4:0]  e_rd;
    int          e_stalls;
    logic        e_err;
  } vec_t;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Entered and left at a negedge; outputs of the final edge are visible on return.
  task automatic run_txn(input vec_t v, output int stalls);
    bit op, done;
    op = v.mr | v.mw;
    RegWrite_i = v.rw; MemtoReg_i = v.m2r; MemRead_i = v.mr; MemWrite_i = v.mw;
    ALU_result_i = v.alu; Write_Data_i = v.wdata; RD_addr_i = v.rd;
    mem_rdata_i = v.rdata;
    stalls = 0;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (k > 0) begin
        @(negedge clk);
        chk("bubble_rw", {31'd0, RegWrite_o}, 32'd0);
        chk("bubble_m2r", {31'd0, MemtoReg_o}, 32'd0);
      end
      mem_ack_i = (k == v.delay);
      #1;
      if (stall_o) stalls++;
      chk("req", {31'd0, mem_req_o}, {31'd0, op && k < TIMEOUT});
      if (op) begin
        chk("we", {31'd0, mem_we_o}, {31'd0, v.mw});
        chk("addr", mem_addr_o, v.alu);
        if (v.mw) chk("wdata", mem_wdata_o, v.wdata);
      end
      @(posedge clk);
      if (!op || k == v.delay) done = 1;
      else if (k == TIMEOUT - 1) begin
        @(negedge clk);
        mem_ack_i = 1'b1;   // ack with no request must be ignored
        #1;
        chk("abort_req", {31'd0, mem_req_o}, 32'd0);
        chk("abort_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk);
        done = 1;
      end
    end
    if (!done) chk("txn_bound", 32'd0, 32'd1);
    @(negedge clk);
    mem_ack_i = 1'b0;
  endtask

  function automatic vec_t mk(input logic rw, m2r, mr, mw, input logic [31:0] alu, wdata,
                              input logic [4:0] rd, input int delay, input logic [31:0] rdata,
                              input logic e_rw, e_m2r, input logic [31:0] e_alu, e_rdata,
                              input logic [4:0] e_rd, input int e_stalls, input logic e_err);
    vec_t v;
    v.rw = rw; v.m2r = m2r; v.mr = mr; v.mw = mw; v.alu = alu; v.wdata = wdata;
    v.rd = rd; v.delay = delay; v.rdata = rdata;
    v.e_rw = e_rw; v.e_m2r = e_m2r; v.e_alu = e_alu; v.e_rdata = e_rdata;
    v.e_rd = e_rd; v.e_stalls = e_stalls; v.e_err = e_err;
    return v;
  endfunction

  task automatic check_wb(input string tag, input logic rw, m2r, input logic [31:0] alu,
                          rdata, input logic [4:0] rd, input logic err);
    chk({tag, "_rw"}, {31'd0, RegWrite_o}, {31'd0, rw});
    chk({tag, "_m2r"}, {31'd0, MemtoReg_o}, {31'd0, m2r});
    chk({tag, "_alu"}, ALU_result_o, alu);
    chk({tag, "_rdata"}, Read_Data_o, rdata);
    chk({tag, "_rd"}, {27'd0, RD_addr_o}, {27'd0, rd});
    chk({tag, "_err"}, {31'd0, bus_err_o}, {31'd0, err});
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    RegWrite_i = 0; MemtoReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
    ALU_result_i = 0; Write_Data_i = 0; RD_addr_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  vec_t tbl[$];
  vec_t v;
  int   st;
  // Transaction-level reference state of MEM/WB
  logic        m_rw, m_m2r, m_err;
  logic [31:0] m_alu, m_rdata;
  logic [4:0]  m_rd;

  initial begin
    // delay >= TIMEOUT means the memory never answers
    tbl.push_back(mk(1,0,0,0, 32'h10, 32'h0, 5'd5, 0, 32'h999,      1,0, 32'h10, 32'h0,        5'd5, 0, 0));
    tbl.push_back(mk(1,1,1,0, 32'h40, 32'h0, 5'd6, 0, 32'hDEADBEEF, 1,1, 32'h40, 32'hDEADBEEF, 5'd6, 0, 0));
    tbl.push_back(mk(1,1,1,0, 32'h40, 32'h0, 5'd7, 3, 32'hCAFE0001, 1,1, 32'h40, 32'hCAFE0001, 5'd7, 3, 0));
    tbl.push_back(mk(0,0,0,1, 32'h80, 32'h1234, 5'd0, 2, 32'h5555,  0,0, 32'h80, 32'hCAFE0001, 5'd0, 2, 0));
    tbl.push_back(mk(0,0,1,1, 32'h84, 32'h55, 5'd0, 1, 32'hFFFF,    0,0, 32'h84, 32'hCAFE0001, 5'd0, 1, 0));
    tbl.push_back(mk(1,1,1,0, 32'hC0, 32'h0, 5'd9, 99, 32'h7777,    0,0, 32'h84, 32'hCAFE0001, 5'd0, 4, 1));
    tbl.push_back(mk(1,0,0,0, 32'h77, 32'h0, 5'd3, 0, 32'h0,        1,0, 32'h77, 32'hCAFE0001, 5'd3, 0, 1));

    do_reset();
    #1;
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    check_wb("rst", 0, 0, 32'h0, 32'h0, 5'd0, 0);

    foreach (tbl[i]) begin
      run_txn(tbl[i], st);
      chk($sformatf("vec%0d_stalls", i), st, tbl[i].e_stalls);
      check_wb($sformatf("vec%0d", i), tbl[i].e_rw, tbl[i].e_m2r, tbl[i].e_alu,
               tbl[i].e_rdata, tbl[i].e_rd, tbl[i].e_err);
    end

    // Reset during the second wait cycle of a load abandons it.
    RegWrite_i = 1; MemtoReg_i = 1; MemRead_i = 1; MemWrite_i = 0;
    ALU_result_i = 32'h100; RD_addr_i = 5'd12; mem_ack_i = 0; mem_rdata_i = 32'hABCD;
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("midrst_req", {31'd0, mem_req_o}, 32'd0);
    chk("midrst_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    RegWrite_i = 0; MemtoReg_i = 0; MemRead_i = 0; ALU_result_i = 0; RD_addr_i = 0;
    #1;
    chk("postrst_req", {31'd0, mem_req_o}, 32'd0);
    chk("postrst_stall", {31'd0, stall_o}, 32'd0);
    check_wb("postrst", 0, 0, 32'h0, 32'h0, 5'd0, 0);
    // A zero-wait load right after reset shows the FSM is back in IDLE.
    run_txn(mk(1,1,1,0, 32'h44, 32'h0, 5'd2, 0, 32'h600D, 1,1, 32'h44, 32'h600D, 5'd2, 0, 0), st);
    chk("postrst_load_stalls", st, 0);
    check_wb("postrst_load", 1, 1, 32'h44, 32'h600D, 5'd2, 0);

    // Randomized transactions against the transaction-level model.
    do_reset();
    m_rw = 0; m_m2r = 0; m_alu = 0; m_rdata = 0; m_rd = 0; m_err = 0;
    for (int n = 0; n < 200; n++) begin
      int kind;
      logic op;
      kind = $urandom_range(0, 3);
      v.rw = $urandom_range(0, 1); v.m2r = $urandom_range(0, 1);
      v.mr = (kind == 1) || (kind == 3);
      v.mw = (kind == 2) || (kind == 3);
      v.alu = $urandom; v.wdata = $urandom; v.rd = 5'($urandom);
      v.delay = $urandom_range(0, TIMEOUT + 1);
      v.rdata = $urandom;
      op = v.mr | v.mw;
      run_txn(v, st);
      if (!op) begin
        m_rw = v.rw; m_m2r = v.m2r; m_alu = v.alu; m_rd = v.rd;
        chk("rnd_stalls", st, 0);
      end else if (v.delay < TIMEOUT) begin
        m_rw = v.rw; m_m2r = v.m2r; m_alu = v.alu; m_rd = v.rd;
        if (!v.mw) m_rdata = v.rdata;
        chk("rnd_stalls", st, v.delay);
      end else begin
        m_rw = 0; m_m2r = 0; m_err = 1;
        chk("rnd_stalls", st, TIMEOUT);
      end
      check_wb("rnd", m_rw, m_m2r, m_alu, m_rdata, m_rd, m_err);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
